layered_logic_pipe: RTL and testbench

Parametrised, pipelined successor to the team's four-input layered logic example. Evaluates the same two-level AND/XOR/OR network bitwise over W-bit operands, with one pipeline register per logic layer and valid/ready handshakes on both sides. Sits between a stimulus source (testbench or upstream block) and the visualisation/trace sink, so per-layer timing and backpressure can be inspected. Each result also carries a ones-count, and a saturating transaction counter is kept.

---
 rtl/layered_logic_pkg.sv | 55 +++++
 rtl/layered_logic_pipe_if.sv | 29 ++
 rtl/layered_logic_pipe_slot.sv | 28 ++
 rtl/layered_logic_pipe.sv | 66 ++++++
 tb/tb_layered_logic_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/layered_logic_pkg.sv
// rtl/layered_logic_pkg.sv - shared types and per-bit layer functions for layered_logic_pipe
package layered_logic_pkg;

    localparam int STAGES = 3;
    // Widest operand the popcount helper handles; the layer functions are per-bit.
    localparam int MAX_W  = 64;
    localparam int CW     = $clog2(MAX_W + 1);

    typedef logic [MAX_W-1:0] lane_t;

    typedef struct packed {
        logic t1;
        logic t2;
        logic t3;
        logic t4;
    } l1_t;

    typedef struct packed {
        logic t5;
        logic t6;
        logic t2;
    } l2_t;

    // The network is bitwise; the top applies these per lane across W bits.
    function automatic l1_t layer1(input logic a, input logic b, input logic c, input logic d);
        l1_t r;
        r.t1 = a & b;
        r.t2 = c & d;
        r.t3 = a ^ c;
        r.t4 = b ^ d;
        return r;
    endfunction

    function automatic l2_t layer2(input l1_t x);
        l2_t r;
        r.t5 = x.t1 | x.t2;
        r.t6 = x.t3 & ~x.t4;
        r.t2 = x.t2;
        return r;
    endfunction

    function automatic logic layer3(input l2_t x);
        return (x.t5 & ~x.t6) | (x.t6 & ~x.t2);
    endfunction

    function automatic logic [CW-1:0] popcount(input lane_t v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/layered_logic_pipe_if.sv
// rtl/layered_logic_pipe_if.sv - operand/result handshake bundle for layered_logic_pipe
interface layered_logic_pipe_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    localparam int OW = $clog2(W + 1);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic [W-1:0]     d;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     f;
    logic [OW-1:0]    f_ones;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, f, f_ones, txn_cnt
    );

    modport slave (
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, f, f_ones, txn_cnt
    );
endinterface

// File: rtl/layered_logic_pipe_slot.sv
// rtl/layered_logic_pipe_slot.sv - one elastic pipeline slot: valid bit plus payload register
module pipe_slot #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    input  logic          ready_next,
    output logic          valid,
    output logic [PW-1:0] data,
    output logic          ready
);
    assign ready = ~valid | ready_next;

    // Payload only moves on a real load, so a stalled or emptied slot keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end
endmodule

// File: rtl/layered_logic_pipe.sv
// rtl/layered_logic_pipe.sv - three-stage AND/XOR/OR network with valid/ready flow control
module layered_logic_pipe
    import layered_logic_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    layered_logic_pipe_if.slave io
);
    localparam int OW = $clog2(W + 1);
    localparam int P1 = 4 * W;
    localparam int P2 = 3 * W;
    localparam int P3 = W + OW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [P1-1:0]     s1_d, s1_q;
    logic [P2-1:0]     s2_d, s2_q;
    logic [P3-1:0]     s3_d, s3_q;
    logic [W-1:0]      f_next;
    logic [CNT_W-1:0]  txn_cnt;

    // Stage payloads are interleaved per lane: lane i owns a 4-bit then 3-bit field.
    for (genvar i = 0; i < W; i++) begin : g_lane
        assign s1_d[4*i +: 4] = layer1(io.a[i], io.b[i], io.c[i], io.d[i]);
        assign s2_d[3*i +: 3] = layer2(s1_q[4*i +: 4]);
        assign f_next[i]      = layer3(s2_q[3*i +: 3]);
    end

    assign s3_d = {f_next, OW'(popcount(lane_t'(f_next)))};

    pipe_slot #(.PW(P1)) u_s1 (
        .clk(clk), .rst(rst),
        .up_valid(io.in_valid), .up_data(s1_d), .ready_next(rdy[1]),
        .valid(v[0]), .data(s1_q), .ready(rdy[0])
    );

    pipe_slot #(.PW(P2)) u_s2 (
        .clk(clk), .rst(rst),
        .up_valid(v[0]), .up_data(s2_d), .ready_next(rdy[2]),
        .valid(v[1]), .data(s2_q), .ready(rdy[1])
    );

    pipe_slot #(.PW(P3)) u_s3 (
        .clk(clk), .rst(rst),
        .up_valid(v[1]), .up_data(s3_d), .ready_next(io.out_ready),
        .valid(v[2]), .data(s3_q), .ready(rdy[2])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt <= '0;
        end else if (v[2] && io.out_ready && txn_cnt != CNT_MAX) begin
            txn_cnt <= txn_cnt + CNT_W'(1);
        end
    end

    assign io.in_ready  = rdy[0];
    assign io.out_valid = v[2];
    assign io.f         = s3_q[P3-1:OW];
    assign io.f_ones    = s3_q[OW-1:0];
    assign io.txn_cnt   = txn_cnt;
endmodule

// File: tb/tb_layered_logic_pipe.sv
// tb/tb_layered_logic_pipe.sv - directed and randomised checks of layered_logic_pipe
module tb_layered_logic_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layered_logic_pipe_if #(.W(8), .CNT_W(16)) bus8 ();
    layered_logic_pipe_if #(.W(1), .CNT_W(3))  bus1 ();

    layered_logic_pipe #(.W(8), .CNT_W(16)) u_dut8 (.clk(clk), .rst(rst), .io(bus8.slave));
    layered_logic_pipe #(.W(1), .CNT_W(3))  u_dut1 (.clk(clk), .rst(rst), .io(bus1.slave));

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [11:0] got8[$];
    logic [11:0] exp8[$];
    logic [1:0]  got1[$];
    int          got1_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus8.out_valid && bus8.out_ready) got8.push_back({bus8.f, bus8.f_ones});
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            got1.push_back({bus1.f, bus1.f_ones});
            got1_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] ref_f(input logic [7:0] a, b, c, d);
        logic [7:0] t5, t6;
        t5 = (a & b) | (c & d);
        t6 = (a ^ c) & ~(b ^ d);
        return (t5 & ~t6) | (t6 & ~(c & d));
    endfunction

    task automatic drive8_random();
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.c = 8'($urandom);
        bus8.d = 8'($urandom);
    endtask

    task automatic push_exp8();
        logic [7:0] fe;
        fe = ref_f(bus8.a, bus8.b, bus8.c, bus8.d);
        exp8.push_back({fe, 4'($countones(fe))});
    endtask

    initial begin
        int k;
        int cy;
        int errs;
        int stalls;
        logic [15:0] exh_tab;

        bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.c = 0; bus8.d = 0; bus8.out_ready = 1;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.c = 0; bus1.d = 0; bus1.out_ready = 1;

        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_out_valid", bus8.out_valid, 0);
        check("rst_f", bus8.f, 0);
        check("rst_f_ones", bus8.f_ones, 0);
        check("rst_txn_cnt", bus8.txn_cnt, 0);
        check("rst_in_ready", bus8.in_ready, 1);
        check("rst_out_valid_w1", bus1.out_valid, 0);

        // single vector, latency 3
        bus8.a = 8'h0B; bus8.b = 8'h05; bus8.c = 8'h09; bus8.d = 8'h01; bus8.in_valid = 1;
        @(posedge clk); #1 bus8.in_valid = 0;
        check("lat_edge1", bus8.out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge2", bus8.out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge3", bus8.out_valid, 1);
        check("single_f", bus8.f, 8'h03);
        check("single_ones", bus8.f_ones, 2);
        @(posedge clk); #1;
        check("single_txn", bus8.txn_cnt, 1);
        check("single_drained", bus8.out_valid, 0);

        // W=1 exhaustive, back-to-back, also saturates the 3-bit counter
        exh_tab = 16'hF90C;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            {bus1.a, bus1.b, bus1.c, bus1.d} = 4'(i);
            bus1.in_valid = 1;
            @(negedge clk);
            if (!bus1.in_ready) stalls++;
            @(posedge clk); #1;
        end
        bus1.in_valid = 0;
        cy = 0;
        while (got1.size() < 16 && cy < 20) begin
            @(posedge clk); #1; cy++;
        end
        check("exh_count", got1.size(), 16);
        check("exh_no_stall", stalls, 0);
        for (int i = 0; i < 16; i++) begin
            if (i < got1.size()) check($sformatf("exh_f_%0d", i), got1[i], {exh_tab[i], exh_tab[i]});
        end
        if (got1_cyc.size() >= 16) check("exh_rate", got1_cyc[15] - got1_cyc[0], 15);
        check("sat_txn_cnt", bus1.txn_cnt, 7);

        // backpressure: 5 vectors with out_ready low
        got8.delete(); exp8.delete();
        bus8.out_ready = 0;
        k = 0;
        for (int c6 = 0; c6 < 6; c6++) begin
            drive8_random();
            bus8.in_valid = 1;
            @(negedge clk);
            if (bus8.in_ready) begin push_exp8(); k++; end
            @(posedge clk); #1;
        end
        check("bp_accepts", k, 3);
        check("bp_in_ready_low", bus8.in_ready, 0);
        check("bp_out_valid", bus8.out_valid, 1);
        check("bp_nothing_out", got8.size(), 0);
        bus8.out_ready = 1;
        cy = 0;
        while (k < 5 && cy < 20) begin
            drive8_random();
            bus8.in_valid = 1;
            @(negedge clk);
            if (bus8.in_ready) begin push_exp8(); k++; end
            @(posedge clk); #1; cy++;
        end
        bus8.in_valid = 0;
        cy = 0;
        while (got8.size() < 5 && cy < 20) begin
            @(posedge clk); #1; cy++;
        end
        check("bp_count", got8.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got8.size() && i < exp8.size()) check($sformatf("bp_res_%0d", i), got8[i], exp8[i]);
        end

        // random valid/ready, 1000 vectors
        rst = 1;
        @(posedge clk); #1 rst = 0;
        got8.delete(); exp8.delete();
        k = 0; cy = 0;
        while ((k < 1000 || got8.size() < 1000) && cy < 8000) begin
            bus8.out_ready = 1'($urandom_range(0, 1));
            if (k < 1000 && $urandom_range(0, 1) == 1) begin
                drive8_random();
                bus8.in_valid = 1;
            end else begin
                bus8.in_valid = 0;
            end
            @(negedge clk);
            if (bus8.in_valid && bus8.in_ready) begin push_exp8(); k++; end
            @(posedge clk); #1; cy++;
        end
        bus8.in_valid = 0;
        bus8.out_ready = 1;
        check("rnd_accepts", k, 1000);
        check("rnd_count", got8.size(), 1000);
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i < got8.size() && i < exp8.size()) begin
                if (got8[i] !== exp8[i]) errs++;
            end
        end
        check("rnd_scoreboard", errs, 0);
        check("rnd_txn_cnt", bus8.txn_cnt, 1000);

        // reset with three entries in flight
        got8.delete();
        bus8.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive8_random();
            bus8.in_valid = 1;
            @(posedge clk); #1;
        end
        bus8.in_valid = 0;
        check("inflight_full", bus8.in_ready, 0);
        rst = 1;
        bus8.out_ready = 1;
        @(posedge clk); #1 rst = 0;
        check("rr_out_valid", bus8.out_valid, 0);
        check("rr_in_ready", bus8.in_ready, 1);
        check("rr_txn_cnt", bus8.txn_cnt, 0);
        check("rr_no_output", got8.size(), 0);
        bus8.a = 8'h0B; bus8.b = 8'h05; bus8.c = 8'h09; bus8.d = 8'h01; bus8.in_valid = 1;
        @(posedge clk); #1 bus8.in_valid = 0;
        check("rr_edge1", bus8.out_valid, 0);
        @(posedge clk); #1;
        check("rr_edge2", bus8.out_valid, 0);
        @(posedge clk); #1;
        check("rr_edge3", bus8.out_valid, 1);
        check("rr_f", bus8.f, 8'h03);
        repeat (2) @(posedge clk);
        #1;
        check("rr_alone_valid", bus8.out_valid, 0);
        check("rr_alone_count", got8.size(), 1);
        check("rr_txn_cnt_after", bus8.txn_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
